// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, the SEQ stage
// state enum and the per-stage output decode used by the stage sequencer.
package y86_pkg;

   localparam logic [3:0] ICODE_HALT   = 4'h0;
   localparam logic [3:0] ICODE_NOP    = 4'h1;
   localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
   localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
   localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
   localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
   localparam logic [3:0] ICODE_OPQ    = 4'h6;
   localparam logic [3:0] ICODE_JXX    = 4'h7;
   localparam logic [3:0] ICODE_CALL   = 4'h8;
   localparam logic [3:0] ICODE_RET    = 4'h9;
   localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
   localparam logic [3:0] ICODE_POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_MEMORY,
      ST_WRITEBACK,
      ST_PCUPD,
      ST_HALT,
      ST_ERROR
   } stage_e;

   typedef struct packed {
      logic fetch;
      logic decode;
      logic exec;
      logic mem;
      logic wb;
      logic pc;
      logic cc_we;
      logic mem_rd;
      logic mem_wr;
      logic busy;
   } stage_outs_t;

   function automatic logic is_read_icode(logic [3:0] ic);
      return (ic == ICODE_MRMOVQ) || (ic == ICODE_RET) || (ic == ICODE_POPQ);
   endfunction

   function automatic logic is_write_icode(logic [3:0] ic);
      return (ic == ICODE_RMMOVQ) || (ic == ICODE_CALL) || (ic == ICODE_PUSHQ);
   endfunction

   function automatic logic is_mem_icode(logic [3:0] ic);
      return is_read_icode(ic) || is_write_icode(ic);
   endfunction

   // Moore outputs for a stage, given the icode latched for the instruction.
   function automatic stage_outs_t stage_outs(stage_e st, logic [3:0] ic);
      stage_outs_t o;
      o = '0;
      case (st)
         ST_FETCH:     o.fetch = 1'b1;
         ST_DECODE:    o.decode = 1'b1;
         ST_EXECUTE: begin
            o.exec  = 1'b1;
            o.cc_we = (ic == ICODE_OPQ);
         end
         ST_MEMORY: begin
            o.mem    = 1'b1;
            o.mem_rd = is_read_icode(ic);
            o.mem_wr = is_write_icode(ic);
         end
         ST_WRITEBACK: o.wb = 1'b1;
         ST_PCUPD:     o.pc = 1'b1;
         default:      ;
      endcase
      o.busy = !((st == ST_IDLE) || (st == ST_HALT) || (st == ST_ERROR));
      return o;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEMORY-stage cycles with mem_ready low; timeout flags the cycle that
// would be the MEM_TIMEOUT-th consecutive wait so the sequencer exits on its edge.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic count_en,
   output logic timeout
);

   localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);

   logic [7:0] count;

   assign timeout = count_en && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && !timeout) begin
         count <= count + 8'd1;
      end
   end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Y86-64 SEQ stage sequencer: one-hot stage enables, memory strobes with timeout,
// status. Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module seq_stage_ctrl
   import y86_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  icode,
   input  logic        instr_valid,
   input  logic        imem_error,
   input  logic        dmem_error,
   input  logic        mem_ready,
   output logic        fetch_en,
   output logic        decode_en,
   output logic        exec_en,
   output logic        mem_en,
   output logic        wb_en,
   output logic        pc_en,
   output logic        cc_we,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [2:0]  stat,
   output logic        busy,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   stage_e      state, state_nxt;
   logic [3:0]  icode_q, icode_nxt;
   logic [2:0]  stat_nxt;
   stage_outs_t outs_q;
   logic        start_armed;
   logic        timeout;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (state == ST_EXECUTE),
      .count_en ((state == ST_MEMORY) && !mem_ready && !dmem_error),
      .timeout  (timeout)
   );

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt = state;
      icode_nxt = icode_q;
      stat_nxt  = stat;
      case (state)
         ST_IDLE: if (start && start_armed) state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (imem_error) begin
               state_nxt = ST_ERROR;
               stat_nxt  = STAT_ADR;
            end else if ((icode > ICODE_POPQ) || !instr_valid) begin
               state_nxt = ST_ERROR;
               stat_nxt  = STAT_INS;
            end else if (icode == ICODE_HALT) begin
               state_nxt = ST_HALT;
               stat_nxt  = STAT_HLT;
            end else begin
               state_nxt = ST_DECODE;
               icode_nxt = icode;
            end
         end
         ST_DECODE:  state_nxt = ST_EXECUTE;
         ST_EXECUTE: state_nxt = is_mem_icode(icode_q) ? ST_MEMORY : ST_WRITEBACK;
         ST_MEMORY: begin
            if (dmem_error || timeout) begin
               state_nxt = ST_ERROR;
               stat_nxt  = STAT_ADR;
            end else if (mem_ready) begin
               state_nxt = ST_WRITEBACK;
            end
         end
         ST_WRITEBACK: state_nxt = ST_PCUPD;
         ST_PCUPD:     state_nxt = ST_FETCH;
         ST_HALT:      state_nxt = ST_HALT;
         ST_ERROR:     state_nxt = ST_ERROR;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: outputs are decoded from the next state and registered with <=, so each
   // output changes on the same edge that enters its state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         icode_q     <= '0;
         stat        <= STAT_AOK;
         outs_q      <= '0;
         start_armed <= 1'b0;
      end else begin
         state       <= state_nxt;
         icode_q     <= icode_nxt;
         stat        <= stat_nxt;
         outs_q      <= stage_outs(state_nxt, icode_nxt);
         start_armed <= 1'b1;
      end
   end

   assign fetch_en  = outs_q.fetch;
   assign decode_en = outs_q.decode;
   assign exec_en   = outs_q.exec;
   assign mem_en    = outs_q.mem;
   assign wb_en     = outs_q.wb;
   assign pc_en     = outs_q.pc;
   assign cc_we     = outs_q.cc_we;
   assign mem_rd    = outs_q.mem_rd;
   assign mem_wr    = outs_q.mem_wr;
   assign busy      = outs_q.busy;

`ifdef SEQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (outs_q.busy && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 32'd1;
         if (outs_q.pc && (instr_cnt != '1))   instr_cnt <= instr_cnt + 32'd1;
      end
   end
`else
   assign cycle_cnt = '0;
   assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: directed scenarios plus random programs
// checked cycle by cycle against a stage-script model of the instruction flow.
module tb_seq_stage_ctrl;
   import y86_pkg::*;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  icode = '0;
   logic        instr_valid = 1'b0;
   logic        imem_error = 1'b0;
   logic        dmem_error = 1'b0;
   logic        mem_ready = 1'b0;
   logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en;
   logic        cc_we, mem_rd, mem_wr, busy;
   logic [2:0]  stat;
   logic [31:0] cycle_cnt, instr_cnt;

   int total = 0;
   int bad = 0;
   int exp_cyc = 0;
   int exp_ins = 0;

   seq_stage_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
      .instr_valid(instr_valid), .imem_error(imem_error),
      .dmem_error(dmem_error), .mem_ready(mem_ready),
      .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
      .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .cc_we(cc_we),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .stat(stat), .busy(busy),
      .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected output vector for a stage letter: I F D E M W P H(alt) X(error).
   function automatic logic [12:0] exp_vec(byte s, logic [3:0] ic, logic [2:0] st);
      logic rd, wr, bsy;
      rd  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
      wr  = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
      bsy = (s == "F") || (s == "D") || (s == "E") || (s == "M") || (s == "W") || (s == "P");
      return {s == "F", s == "D", s == "E", s == "M", s == "W", s == "P",
              (s == "E") && (ic == 4'h6), (s == "M") && rd, (s == "M") && wr, bsy, st};
   endfunction

   task automatic expect_cycle(input byte s, input logic [3:0] ic, input logic [2:0] st,
                               input string tag);
      logic [31:0] ec, ei;
      check(tag, {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_we,
                  mem_rd, mem_wr, busy, stat}, exp_vec(s, ic, st));
`ifdef SEQ_PERF_CNT_EN
      ec = 32'(exp_cyc);
      ei = 32'(exp_ins);
`else
      ec = '0;
      ei = '0;
`endif
      check({tag, "_cyc"}, cycle_cnt, ec);
      check({tag, "_ins"}, instr_cnt, ei);
      if (exp_vec(s, ic, st) & 13'h008) exp_cyc++;
      if (s == "P") exp_ins++;
   endtask

   // Inputs that are meaningless in the current stage get junk values.
   task automatic junk();
      start       = 1'($urandom);
      icode       = 4'($urandom);
      instr_valid = 1'($urandom);
      imem_error  = 1'($urandom);
      dmem_error  = 1'($urandom);
      mem_ready   = 1'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_cyc = 0;
      exp_ins = 0;
      #1;
      expect_cycle("I", 4'h0, STAT_AOK, "reset");
      @(negedge clk);
      start = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      expect_cycle("I", 4'h0, STAT_AOK, "start_at_release");
      start = 1'b0;
   endtask

   task automatic launch();
      @(negedge clk);
      expect_cycle("I", 4'h0, STAT_AOK, "idle");
      start = 1'b1;
      @(negedge clk);
   endtask

   // Runs one instruction from its FETCH cycle; returns AOK or the terminal status.
   task automatic run_instr(input logic [3:0] ic, input logic vld, input logic ierr,
                            input int waits, input logic derr, input logic rdy_err,
                            output logic [2:0] outcome);
      outcome = STAT_AOK;
      expect_cycle("F", ic, STAT_AOK, "fetch");
      junk();
      icode = ic; instr_valid = vld; imem_error = ierr;
      @(negedge clk);
      if (ierr) begin outcome = STAT_ADR; return; end
      if ((ic > 4'hB) || !vld) begin outcome = STAT_INS; return; end
      if (ic == 4'h0) begin outcome = STAT_HLT; return; end
      expect_cycle("D", ic, STAT_AOK, "decode");
      junk();
      @(negedge clk);
      expect_cycle("E", ic, STAT_AOK, "execute");
      junk();
      @(negedge clk);
      if ((ic == 4'h4) || (ic == 4'h5) || (ic >= 4'h8)) begin
         for (int k = 0; ; k++) begin
            expect_cycle("M", ic, STAT_AOK, "memory");
            junk();
            if (k < waits) begin
               mem_ready = 1'b0; dmem_error = 1'b0;
               @(negedge clk);
               if (k + 1 == TMO) begin outcome = STAT_ADR; return; end
            end else begin
               mem_ready = derr ? rdy_err : 1'b1;
               dmem_error = derr;
               @(negedge clk);
               if (derr) begin outcome = STAT_ADR; return; end
               break;
            end
         end
      end
      expect_cycle("W", ic, STAT_AOK, "writeback");
      junk();
      @(negedge clk);
      expect_cycle("P", ic, STAT_AOK, "pcupd");
      junk();
      @(negedge clk);
   endtask

   task automatic check_terminal(input logic [2:0] st);
      for (int i = 0; i < 3; i++) begin
         expect_cycle((st == STAT_HLT) ? "H" : "X", 4'h0, st, "terminal");
         junk();
         start = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic run_and_halt(input logic [3:0] ic, input int waits, input logic [2:0] want);
      logic [2:0] oc;
      run_instr(ic, 1'b1, 1'b0, waits, 1'b0, 1'b0, oc);
      check("outcome", oc, want);
      if (oc == STAT_AOK) begin
         run_instr(4'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, oc);
         check("halt_outcome", oc, STAT_HLT);
      end
      check_terminal(oc);
   endtask

   initial begin
      logic [2:0] oc;

      // OPq: five stages, cc_we only in execute, one retired instruction.
      do_reset(); launch();
      run_and_halt(ICODE_OPQ, 0, STAT_AOK);
      check("opq_instr", exp_ins, 1);

      // mrmovq with three wait cycles, then pushq timing out.
      do_reset(); launch();
      run_and_halt(ICODE_MRMOVQ, 3, STAT_AOK);
      do_reset(); launch();
      run_and_halt(ICODE_PUSHQ, 1000, STAT_ADR);
      do_reset(); launch();
      run_and_halt(ICODE_POPQ, TMO - 1, STAT_AOK);

      // Fetch fault priority.
      do_reset(); launch();
      run_instr(4'hC, 1'b1, 1'b1, 0, 1'b0, 1'b0, oc); check_terminal(oc);
      do_reset(); launch();
      run_instr(4'hC, 1'b1, 1'b0, 0, 1'b0, 1'b0, oc); check_terminal(oc);
      do_reset(); launch();
      run_instr(4'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, oc); check_terminal(oc);

      // dmem_error beats a simultaneous mem_ready.
      do_reset(); launch();
      run_instr(ICODE_MRMOVQ, 1'b1, 1'b0, 0, 1'b1, 1'b1, oc); check_terminal(oc);

      // Reset in the middle of a call's memory wait, then a clean restart.
      do_reset(); launch();
      expect_cycle("F", 4'h8, STAT_AOK, "rst_fetch");
      junk(); icode = 4'h8; instr_valid = 1'b1; imem_error = 1'b0;
      @(negedge clk);
      expect_cycle("D", 4'h8, STAT_AOK, "rst_decode"); junk(); @(negedge clk);
      expect_cycle("E", 4'h8, STAT_AOK, "rst_exec");   junk(); @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         expect_cycle("M", 4'h8, STAT_AOK, "rst_mem");
         junk(); mem_ready = 1'b0; dmem_error = 1'b0;
         @(negedge clk);
      end
      rst_n = 1'b0;
      exp_cyc = 0;
      exp_ins = 0;
      #1;
      expect_cycle("I", 4'h0, STAT_AOK, "mid_mem_reset");
      @(negedge clk);
      start = 1'b0; rst_n = 1'b1;
      launch();
      run_and_halt(ICODE_OPQ, 0, STAT_AOK);

      // Random programs.
      for (int p = 0; p < 30; p++) begin
         do_reset(); launch();
         oc = STAT_AOK;
         for (int n = 0; n < 6 && oc == STAT_AOK; n++) begin
            logic [3:0] ic;
            int waits;
            ic = ($urandom % 4 == 0) ? 4'($urandom) : 4'(1 + $urandom % 11);
            waits = ($urandom % 6 == 0) ? 12 + int'($urandom % 9) : int'($urandom % 4);
            run_instr(ic, 1'($urandom % 8 != 0), 1'($urandom % 16 == 0), waits,
                      1'($urandom % 8 == 0), 1'($urandom), oc);
         end
         if (oc == STAT_AOK) run_instr(4'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0, oc);
         check_terminal(oc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
